// File: rtl/hazard3_trigger_break_ctrl_pkg.sv
// Shared definitions for the trigger break controller: state encoding and
// the trap cause codes reported alongside the requests.
package hazard3_trigger_break_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_SUPPRESS = 2'd2
    } brk_state_e;

    localparam logic [3:0] MCAUSE_BREAKPOINT  = 4'd3;
    localparam logic [2:0] DCSR_CAUSE_TRIGGER = 3'd2;

endpackage

// File: rtl/hazard3_trigger_break_ctrl.sv
// Qualifies trigger-unit matches, holds the matching instruction, and issues a
// single M-mode breakpoint or D-mode halt request until acked or flushed.
module hazard3_trigger_break_ctrl
    import hazard3_trigger_break_ctrl_pkg::*;
#(
    parameter int W_ADDR             = 32,
    parameter int SUPPRESS_ON_RESUME = 1,
    parameter int W_HITCNT           = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                break_any,
    input  logic                break_d_mode,
    input  logic [W_ADDR-1:0]   pc,
    input  logic                instr_valid,
    input  logic                stage_adv,
    input  logic                flush,
    input  logic                trap_ack,
    input  logic                dbg_resume,
    input  logic                d_mode,
    output logic                hold,
    output logic                trap_req_m,
    output logic                halt_req_d,
    output logic [W_ADDR-1:0]   hit_pc,
    output logic [W_HITCNT-1:0] hit_count
);

    function automatic logic [W_HITCNT-1:0] sat_inc(input logic [W_HITCNT-1:0] c);
        return (&c) ? c : c + W_HITCNT'(1);
    endfunction

    brk_state_e          state_r;
    brk_state_e          state_next_s;
    logic                kind_d_r;
    logic                kind_next_s;
    logic [W_ADDR-1:0]   hit_pc_r;
    logic [W_ADDR-1:0]   pc_next_s;
    logic [W_HITCNT-1:0] hit_count_r;
    logic [W_HITCNT-1:0] cnt_next_s;
    logic                trap_req_m_r;
    logic                halt_req_d_r;
    logic                fire_s;
    logic                hold_s;

    assign fire_s = instr_valid && break_any && !d_mode && !flush;

    // Next-state, latched-hit and hold decode
    always_comb begin
        state_next_s = state_r;
        kind_next_s  = kind_d_r;
        pc_next_s    = hit_pc_r;
        cnt_next_s   = hit_count_r;
        hold_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                hold_s = fire_s;
                if (fire_s) begin
                    state_next_s = ST_ARMED;
                    kind_next_s  = break_d_mode;
                    pc_next_s    = pc;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                hold_s = 1'b1;
                // An ack in the same cycle as a flush still counts as taken
                if (trap_ack) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = sat_inc(hit_count_r);
                end else if (flush) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ARMED;
                end
            end
            ST_SUPPRESS: begin
                hold_s = 1'b0;
                if (flush || d_mode || (instr_valid && stage_adv)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SUPPRESS;
                end
            end
            default: begin
                hold_s       = 1'b0;
                state_next_s = ST_IDLE;
            end
        endcase
        // Resume overrides whatever the state-specific handling chose
        if (dbg_resume) begin
            state_next_s = (SUPPRESS_ON_RESUME != 0) ? ST_SUPPRESS : ST_IDLE;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State, latched hit and registered request outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            kind_d_r     <= 1'b0;
            hit_pc_r     <= '0;
            hit_count_r  <= '0;
            trap_req_m_r <= 1'b0;
            halt_req_d_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            kind_d_r     <= kind_next_s;
            hit_pc_r     <= pc_next_s;
            hit_count_r  <= cnt_next_s;
            trap_req_m_r <= (state_next_s == ST_ARMED) && !kind_next_s;
            halt_req_d_r <= (state_next_s == ST_ARMED) && kind_next_s;
        end
    end

    assign hold       = hold_s;
    assign trap_req_m = trap_req_m_r;
    assign halt_req_d = halt_req_d_r;
    assign hit_pc     = hit_pc_r;
    assign hit_count  = hit_count_r;

endmodule

// File: tb/tb_hazard3_trigger_break_ctrl.sv
// Table-driven bench for hazard3_trigger_break_ctrl with a queue of pending
// registered-output expectations checked one cycle after each vector.
module tb_hazard3_trigger_break_ctrl;

    localparam int W_ADDR   = 32;
    localparam int W_HITCNT = 8;

    typedef struct {
        logic              rst;
        logic              bany;
        logic              bd;
        logic [W_ADDR-1:0] pc;
        logic              iv;
        logic              adv;
        logic              flush;
        logic              ack;
        logic              resume;
        logic              dmode;
        logic              e_hold;
        logic              e_trap;
        logic              e_halt;
        logic              e_pc_chk;
        logic [W_ADDR-1:0] e_pc;
        logic [7:0]        e_cnt;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst, break_any, break_d_mode, instr_valid, stage_adv;
    logic                flush, trap_ack, dbg_resume, d_mode;
    logic [W_ADDR-1:0]   pc;
    logic                hold, trap_req_m, halt_req_d;
    logic [W_ADDR-1:0]   hit_pc;
    logic [W_HITCNT-1:0] hit_count;

    int n_vec = 0;
    int n_err = 0;
    vec_t sb_q[$];
    vec_t tbl[24];
    int   n_tbl = 0;

    hazard3_trigger_break_ctrl #(
        .W_ADDR(W_ADDR), .SUPPRESS_ON_RESUME(1), .W_HITCNT(W_HITCNT)
    ) dut (
        .clk(clk), .rst(rst), .break_any(break_any), .break_d_mode(break_d_mode),
        .pc(pc), .instr_valid(instr_valid), .stage_adv(stage_adv), .flush(flush),
        .trap_ack(trap_ack), .dbg_resume(dbg_resume), .d_mode(d_mode),
        .hold(hold), .trap_req_m(trap_req_m), .halt_req_d(halt_req_d),
        .hit_pc(hit_pc), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic ba, input logic bd,
                                input logic [31:0] p, input logic iv, input logic adv,
                                input logic fl, input logic ak, input logic rs,
                                input logic dm, input logic eh, input logic et,
                                input logic ed, input logic epc_chk,
                                input logic [31:0] epc, input logic [7:0] ec);
        vec_t v;
        v.rst = r; v.bany = ba; v.bd = bd; v.pc = p; v.iv = iv; v.adv = adv;
        v.flush = fl; v.ack = ak; v.resume = rs; v.dmode = dm;
        v.e_hold = eh; v.e_trap = et; v.e_halt = ed; v.e_pc_chk = epc_chk;
        v.e_pc = epc; v.e_cnt = ec;
        return v;
    endfunction

    task automatic add(input vec_t v);
        tbl[n_tbl] = v;
        n_tbl++;
    endtask

    task automatic check_pending(input string tag);
        vec_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (trap_req_m !== e.e_trap || halt_req_d !== e.e_halt || hit_count !== e.e_cnt) begin
                n_err++;
                $display("FAIL %s req: got trap=%0b halt=%0b cnt=%0d, want trap=%0b halt=%0b cnt=%0d",
                         tag, trap_req_m, halt_req_d, hit_count, e.e_trap, e.e_halt, e.e_cnt);
            end
            if (e.e_pc_chk || e.e_trap || e.e_halt) begin
                n_vec++;
                if (hit_pc !== e.e_pc) begin
                    n_err++;
                    $display("FAIL %s hit_pc: got %h want %h", tag, hit_pc, e.e_pc);
                end
            end
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        check_pending(tag);
        rst = v.rst; break_any = v.bany; break_d_mode = v.bd; pc = v.pc;
        instr_valid = v.iv; stage_adv = v.adv; flush = v.flush; trap_ack = v.ack;
        dbg_resume = v.resume; d_mode = v.dmode;
        #1;
        n_vec++;
        if (hold !== v.e_hold) begin
            n_err++;
            $display("FAIL %s hold: got %0b want %0b", tag, hold, v.e_hold);
        end
        sb_q.push_back(v);
    endtask

    task automatic drain(input string tag);
        @(posedge clk);
        #1;
        check_pending(tag);
        rst = 1'b0; break_any = 1'b0; instr_valid = 1'b0; trap_ack = 1'b0;
        flush = 1'b0; dbg_resume = 1'b0; d_mode = 1'b0; stage_adv = 1'b0;
    endtask

    initial begin
        rst = 1'b1; break_any = 1'b0; break_d_mode = 1'b0; pc = '0; instr_valid = 1'b0;
        stage_adv = 1'b0; flush = 1'b0; trap_ack = 1'b0; dbg_resume = 1'b0; d_mode = 1'b0;
        repeat (2) @(posedge clk);

        //     rst ba bd pc          iv adv fl ak rs dm   hold trap halt pchk epc         cnt
        add(mk(1, 0, 0, 32'h0,     0, 0, 0, 0, 0, 0,   0,   0,   0,   1,   32'h0,     8'd0)); // reset
        add(mk(0, 1, 0, 32'h100,   1, 0, 0, 0, 0, 0,   1,   1,   0,   1,   32'h100,   8'd0)); // m hit
        add(mk(0, 0, 0, 32'h104,   0, 0, 0, 0, 0, 0,   1,   1,   0,   1,   32'h100,   8'd0)); // held
        add(mk(0, 0, 0, 32'h104,   0, 0, 0, 1, 0, 0,   1,   0,   0,   0,   32'h0,     8'd1)); // ack
        add(mk(0, 1, 1, 32'h140,   1, 0, 1, 0, 0, 0,   0,   0,   0,   0,   32'h0,     8'd1)); // d hit+flush
        add(mk(0, 1, 1, 32'h140,   1, 0, 0, 0, 0, 0,   1,   0,   1,   1,   32'h140,   8'd1)); // d hit
        add(mk(0, 0, 0, 32'h0,     0, 0, 1, 1, 0, 0,   1,   0,   0,   0,   32'h0,     8'd2)); // ack+flush
        add(mk(0, 1, 0, 32'h180,   1, 0, 0, 0, 0, 0,   1,   1,   0,   1,   32'h180,   8'd2)); // m hit
        add(mk(0, 0, 0, 32'h0,     0, 0, 1, 0, 0, 0,   1,   0,   0,   0,   32'h0,     8'd2)); // flush only
        add(mk(0, 1, 0, 32'h1c0,   1, 0, 0, 0, 0, 1,   0,   0,   0,   0,   32'h0,     8'd2)); // in d_mode
        add(mk(0, 1, 0, 32'h1c0,   0, 0, 0, 0, 0, 0,   0,   0,   0,   0,   32'h0,     8'd2)); // invalid
        add(mk(0, 1, 1, 32'h200,   1, 0, 0, 0, 0, 0,   1,   0,   1,   1,   32'h200,   8'd2)); // halt hit
        add(mk(0, 0, 0, 32'h0,     0, 0, 0, 1, 0, 0,   1,   0,   0,   0,   32'h0,     8'd3)); // ack
        add(mk(0, 0, 0, 32'h0,     0, 0, 0, 0, 0, 1,   0,   0,   0,   0,   32'h0,     8'd3)); // in debug
        add(mk(0, 0, 0, 32'h0,     0, 0, 0, 0, 1, 1,   0,   0,   0,   0,   32'h0,     8'd3)); // resume
        add(mk(0, 1, 1, 32'h200,   1, 0, 0, 0, 0, 0,   0,   0,   0,   0,   32'h0,     8'd3)); // suppressed, stalled
        add(mk(0, 1, 1, 32'h200,   1, 1, 0, 0, 0, 0,   0,   0,   0,   0,   32'h0,     8'd3)); // suppressed advance
        add(mk(0, 1, 1, 32'h200,   1, 0, 0, 0, 0, 0,   1,   0,   1,   1,   32'h200,   8'd3)); // second arrival
        add(mk(0, 0, 0, 32'h0,     0, 0, 0, 1, 0, 0,   1,   0,   0,   0,   32'h0,     8'd4)); // ack
        add(mk(0, 1, 0, 32'h300,   1, 0, 0, 0, 0, 0,   1,   1,   0,   1,   32'h300,   8'd4)); // m hit
        add(mk(1, 0, 0, 32'h0,     0, 0, 0, 0, 0, 0,   1,   0,   0,   1,   32'h0,     8'd0)); // rst in armed

        for (int i = 0; i < n_tbl; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Saturation: 260 acked hits, count must stick at 255
        for (int i = 0; i < 260; i++) begin
            logic [7:0] ec;
            logic [31:0] hp;
            ec = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            hp = 32'h1000 + 32'(i * 4);
            apply(mk(0, 1, 0, hp, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, hp,
                     (i > 255) ? 8'd255 : 8'(i)), $sformatf("sat_hit%0d", i));
            apply(mk(0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 32'h0, ec),
                  $sformatf("sat_ack%0d", i));
        end
        apply(mk(0, 1, 0, 32'h4000, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h4000, 8'd255), "sat_armed");
        apply(mk(1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0, 8'd0), "sat_rst");
        drain("drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
